// File: rtl/hcsr04_multi_ranger.sv
// Round-robin controller for N_CH HC-SR04-class ultrasonic rangers.
// Fires one sensor per slot, measures its echo width and publishes a scaled, saturated distance.
module hcsr04_multi_ranger #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CH_W          = 2,
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned PERIOD_CYCLES = 3000000,
    parameter int unsigned CNT_W         = 22,
    parameter int unsigned SCALE         = 891,
    parameter int unsigned SHIFT         = 18,
    parameter int unsigned DIST_W        = 12
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic [N_CH-1:0]          echo_in,
    output logic [N_CH-1:0]          trigger_out,
    output logic [DIST_W-1:0]        dist_data,
    output logic [CH_W-1:0]          dist_ch,
    output logic                     dist_timeout,
    output logic                     dist_valid,
    output logic [N_CH*DIST_W-1:0]   dist_all,
    output logic                     busy
);

    localparam int unsigned PW = CNT_W + 10;
    localparam int unsigned XW = PW + DIST_W;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [PW-1:0]    SCALE_P   = PW'(SCALE);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       w_q, w_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [N_CH-1:0]        echo_meta_q, echo_s_q;
    logic [N_CH-1:0]        trigger_q, trigger_d;
    logic [DIST_W-1:0]      dist_data_q, dist_data_d;
    logic [CH_W-1:0]        dist_ch_q, dist_ch_d;
    logic                   dist_to_q, dist_to_d;
    logic                   dist_valid_q, dist_valid_d;
    logic [N_CH*DIST_W-1:0] dist_all_q, dist_all_d;

    logic                   echo_act;
    logic                   pub_meas, pub_to;
    logic [PW-1:0]          product;
    logic [XW-1:0]          shifted;
    logic [DIST_W-1:0]      meas_dist, pub_val;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            echo_meta_q <= '0;
            echo_s_q    <= '0;
        end else begin
            echo_meta_q <= echo_in;
            echo_s_q    <= echo_meta_q;
        end
    end

    always_comb begin
        echo_act = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) echo_act = echo_s_q[i];
        end
    end

    // Anything at or above 2^DIST_W after the shift saturates to all ones.
    always_comb begin
        product   = PW'(w_q) * SCALE_P;
        shifted   = XW'(product) >> SHIFT;
        meas_dist = (|shifted[XW-1:DIST_W]) ? '1 : shifted[DIST_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        ch_d     = ch_q;
        pub_meas = 1'b0;
        pub_to   = 1'b0;
        if (state_q != IDLE) cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (en) begin
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_act) begin
                    w_d     = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (echo_act) begin
                    w_d = w_q + 1'b1;
                end else begin
                    pub_meas = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase

        // Slot end overrides the per-state move; a fall seen this same cycle still publishes.
        if (state_q != IDLE && cnt_q == SLOT_LAST) begin
            pub_to  = (state_q == WAIT_RISE) || (state_q == MEASURE && echo_act);
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            cnt_d   = '0;
            state_d = en ? TRIG : IDLE;
        end
    end

    always_comb begin
        trigger_d    = '0;
        dist_valid_d = pub_meas | pub_to;
        dist_data_d  = dist_data_q;
        dist_ch_d    = dist_ch_q;
        dist_to_d    = dist_to_q;
        dist_all_d   = dist_all_q;
        pub_val      = pub_to ? '1 : meas_dist;

        for (int unsigned i = 0; i < N_CH; i++) begin
            trigger_d[i] = (state_d == TRIG) && (ch_d == CH_W'(i));
        end

        if (dist_valid_d) begin
            dist_data_d = pub_val;
            dist_ch_d   = ch_q;
            dist_to_d   = pub_to;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (ch_q == CH_W'(i)) dist_all_d[i*DIST_W +: DIST_W] = pub_val;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            w_q          <= '0;
            ch_q         <= '0;
            trigger_q    <= '0;
            dist_data_q  <= '0;
            dist_ch_q    <= '0;
            dist_to_q    <= 1'b0;
            dist_valid_q <= 1'b0;
            dist_all_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            w_q          <= w_d;
            ch_q         <= ch_d;
            trigger_q    <= trigger_d;
            dist_data_q  <= dist_data_d;
            dist_ch_q    <= dist_ch_d;
            dist_to_q    <= dist_to_d;
            dist_valid_q <= dist_valid_d;
            dist_all_q   <= dist_all_d;
        end
    end

    assign trigger_out  = trigger_q;
    assign dist_data    = dist_data_q;
    assign dist_ch      = dist_ch_q;
    assign dist_timeout = dist_to_q;
    assign dist_valid   = dist_valid_q;
    assign dist_all     = dist_all_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hcsr04_multi_ranger.sv
// Bench for hcsr04_multi_ranger: waveform-level reference model compared every cycle,
// plus directed literal expectations and randomized echo slots.
module tb_hcsr04_multi_ranger;

    localparam int N     = 2;
    localparam int CW    = 1;
    localparam int TRIG  = 4;
    localparam int P     = 128;
    localparam int CNTW  = 8;
    localparam int SCALE = 891;
    localparam int SHIFT = 8;
    localparam int DW    = 8;
    localparam int HMAX  = 16384;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  echo_in = '0;
    logic [N-1:0]  trigger_out;
    logic [DW-1:0] dist_data;
    logic [CW-1:0] dist_ch;
    logic          dist_timeout;
    logic          dist_valid;
    logic [N*DW-1:0] dist_all;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    hcsr04_multi_ranger #(
        .N_CH(N), .CH_W(CW), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(P), .CNT_W(CNTW),
        .SCALE(SCALE), .SHIFT(SHIFT), .DIST_W(DW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .echo_in(echo_in),
        .trigger_out(trigger_out), .dist_data(dist_data), .dist_ch(dist_ch),
        .dist_timeout(dist_timeout), .dist_valid(dist_valid), .dist_all(dist_all),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Pin / control history, one entry per cycle, recorded mid-cycle.
    logic [N-1:0] pin_h [HMAX];
    bit           en_h  [HMAX];
    bit           rst_h [HMAX];

    // Model state: slot start cycle, channel, whether this slot has published.
    bit            m_active = 0;
    bit            m_pub = 0;
    int            m_ts = 0;
    int            m_ch = 0;
    logic [DW-1:0] e_data = '0;
    int            e_ch = 0;
    bit            e_to = 0;
    bit            e_valid = 0;
    logic [N*DW-1:0] e_all = '0;
    logic [N-1:0]  e_trig;

    // Synchronized echo as seen inside the design: pin delayed two cycles.
    function automatic bit es(input int c, input int t);
        if (t < 2) return 1'b0;
        if (!rst_h[t-1] || !rst_h[t-2]) return 1'b0;
        return pin_h[t-2][c];
    endfunction

    task automatic publish(input bit to, input int w);
        int d;
        if (to) d = (1 << DW) - 1;
        else begin
            d = (w * SCALE) >> SHIFT;
            if (d > (1 << DW) - 1) d = (1 << DW) - 1;
        end
        e_data = d[DW-1:0];
        e_ch = m_ch;
        e_to = to;
        e_valid = 1'b1;
        m_pub = 1'b1;
        e_all[m_ch*DW +: DW] = d[DW-1:0];
    endtask

    // Search the echo waveform of this slot for a rise and the following fall.
    task automatic try_measure(input int n);
        int r;
        int f;
        r = -1;
        f = -1;
        for (int t = m_ts + TRIG; t <= n - 1 && t <= m_ts + P - 2; t++) begin
            if (es(m_ch, t)) begin r = t; break; end
        end
        if (r >= 0) begin
            for (int t = r + 1; t <= n - 1 && t <= m_ts + P - 1; t++) begin
                if (!es(m_ch, t)) begin f = t; break; end
            end
        end
        if (f >= 0 && f == n - 1) publish(1'b0, f - r);
    endtask

    always @(negedge clk) begin
        int n;
        n = cyc;
        if (n < HMAX) begin
            pin_h[n] = echo_in;
            en_h[n]  = en;
            rst_h[n] = n_rst;
            e_valid  = 1'b0;
            if (!n_rst) begin
                m_active = 0; m_ch = 0; e_data = '0; e_ch = 0; e_to = 0; e_all = '0;
            end else if (m_active) begin
                if (!m_pub) try_measure(n);
                if (n == m_ts + P) begin
                    if (!m_pub) publish(1'b1, 0);
                    m_ch = (m_ch + 1) % N;
                    if (en_h[n-1]) begin m_ts = n; m_pub = 0; end
                    else m_active = 0;
                end
            end else if (n > 0 && rst_h[n-1] && en_h[n-1]) begin
                m_active = 1; m_ts = n; m_pub = 0;
            end
            e_trig = '0;
            if (n_rst && m_active && n < m_ts + TRIG) e_trig[m_ch] = 1'b1;
            chk("trigger_out", 64'(trigger_out), 64'(e_trig));
            chk("busy", 64'(busy), 64'(n_rst && m_active));
            chk("dist_valid", 64'(dist_valid), 64'(e_valid));
            chk("dist_data", 64'(dist_data), 64'(e_data));
            chk("dist_ch", 64'(dist_ch), 64'(e_ch));
            chk("dist_timeout", 64'(dist_timeout), 64'(e_to));
            chk("dist_all", 64'(dist_all), 64'(e_all));
        end
    end

    // Trigger edge monitor for the directed timing checks.
    logic [N-1:0] prev_trig = '0;
    int rise_cyc = -1;
    int rise_ch = 0;
    int fall_cyc = -1;
    always @(negedge clk) begin
        if (trigger_out != '0 && prev_trig == '0) begin
            rise_cyc = cyc;
            for (int i = 0; i < N; i++) if (trigger_out[i]) rise_ch = i;
        end
        if (trigger_out == '0 && prev_trig != '0) fall_cyc = cyc;
        prev_trig = trigger_out;
    end

    int ts = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_off(input int j);
        while (cyc - ts < j) tick();
    endtask

    task automatic wait_rise(input int mincyc, output int ch);
        int k;
        k = 0;
        #1;
        while (rise_cyc < mincyc && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("trigger_rise_seen", 64'(rise_cyc >= mincyc), 64'(1));
        ts = rise_cyc;
        ch = rise_ch;
    endtask

    task automatic wait_valid(output int vc);
        int k;
        k = 0;
        @(negedge clk);
        #1;
        while (!dist_valid && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("dist_valid_seen", 64'(dist_valid), 64'(1));
        vc = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ch;
        int ts0;
        int vc;
        int seen;
        int mode;
        int st;
        int wd;
        bit drop;
        logic [N-1:0] v;

        repeat (3) tick();
        chk("reset_trigger", 64'(trigger_out), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_dist_all", 64'(dist_all), 64'(0));
        n_rst = 1'b1;
        tick();
        en = 1'b1;

        // Basic measurement, channel 0, 10-clock echo.
        wait_rise(cyc, ch);
        ts0 = ts;
        chk("first_slot_ch", 64'(ch), 64'(0));
        goto_off(5); echo_in[0] = 1'b1;
        chk("trigger_len", 64'(fall_cyc - ts), 64'(TRIG));
        goto_off(15); echo_in[0] = 1'b0;
        wait_valid(vc);
        chk("basic_data", 64'(dist_data), 64'(34));
        chk("basic_ch", 64'(dist_ch), 64'(0));
        chk("basic_to", 64'(dist_timeout), 64'(0));
        chk("basic_all0", 64'(dist_all[7:0]), 64'(34));

        // Round robin: channel 1 exactly one period later, 20-clock echo.
        wait_rise(cyc, ch);
        chk("rr_ch", 64'(ch), 64'(1));
        chk("rr_spacing", 64'(ts - ts0), 64'(P));
        goto_off(5); echo_in[1] = 1'b1;
        goto_off(25); echo_in[1] = 1'b0;
        wait_valid(vc);
        chk("rr_data", 64'(dist_data), 64'(69));
        chk("rr_ch_out", 64'(dist_ch), 64'(1));
        chk("rr_all1", 64'(dist_all[15:8]), 64'(69));
        chk("rr_all0_kept", 64'(dist_all[7:0]), 64'(34));

        // Timeout with no echo on channel 0.
        wait_rise(cyc, ch);
        wait_valid(vc);
        chk("to_none_data", 64'(dist_data), 64'(255));
        chk("to_none_flag", 64'(dist_timeout), 64'(1));
        chk("to_none_ch", 64'(dist_ch), 64'(0));
        chk("to_none_at_slot_end", 64'(vc - ts), 64'(P));

        // Timeout with echo stuck high through slot end on channel 1.
        wait_rise(vc, ch);
        goto_off(5); echo_in[1] = 1'b1;
        wait_valid(vc);
        chk("to_stuck_data", 64'(dist_data), 64'(255));
        chk("to_stuck_flag", 64'(dist_timeout), 64'(1));
        chk("to_stuck_ch", 64'(dist_ch), 64'(1));

        // Saturation: 80 clocks gives 278, clipped to 255.
        wait_rise(vc, ch);
        goto_off(1); echo_in[1] = 1'b0;
        goto_off(5); echo_in[0] = 1'b1;
        goto_off(85); echo_in[0] = 1'b0;
        wait_valid(vc);
        chk("sat_data", 64'(dist_data), 64'(255));
        chk("sat_flag", 64'(dist_timeout), 64'(0));

        // Fall seen on the slot-end cycle: measurement wins, slot ends on schedule.
        wait_rise(cyc, ch);
        chk("edge_ch", 64'(ch), 64'(1));
        goto_off(100); echo_in[1] = 1'b1;
        goto_off(125); echo_in[1] = 1'b0;
        wait_valid(vc);
        chk("edge_data", 64'(dist_data), 64'(87));
        chk("edge_flag", 64'(dist_timeout), 64'(0));
        chk("edge_valid_cycle", 64'(vc - ts), 64'(P));

        // Echo already high on entry to WAIT_RISE counts as the rise.
        wait_rise(vc, ch);
        goto_off(1); echo_in[0] = 1'b1;
        goto_off(11); echo_in[0] = 1'b0;
        wait_valid(vc);
        chk("prehigh_data", 64'(dist_data), 64'(31));

        // en dropped mid-slot: slot completes, then idle with no trigger.
        wait_rise(cyc, ch);
        goto_off(10); en = 1'b0;
        wait_valid(vc);
        chk("endrop_valid_cycle", 64'(vc - ts), 64'(P));
        tick();
        chk("endrop_busy", 64'(busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (trigger_out != '0 || busy) seen++;
        end
        chk("endrop_quiet", 64'(seen), 64'(0));
        en = 1'b1;

        // Randomized slots checked by the model.
        for (int s = 0; s < 16; s++) begin
            wait_rise(cyc, ch);
            mode = $urandom_range(0, 3);
            st   = (mode == 3) ? $urandom_range(1, 4) : $urandom_range(5, 100);
            wd   = (mode == 2) ? 200 : $urandom_range(1, 110);
            drop = ($urandom_range(0, 5) == 0);
            for (int j = 1; j < P; j++) begin
                goto_off(j);
                v = echo_in;
                for (int o = 0; o < N; o++) begin
                    if (o == ch) v[o] = (mode != 0 && j >= st && j < st + wd);
                    else if ($urandom_range(0, 7) == 0) v[o] = ~v[o];
                end
                if (j == P - 1) v = '0;
                echo_in = v;
                if (drop && j == 60) en = 1'b0;
            end
            if (drop) begin
                repeat (5) tick();
                en = 1'b1;
            end
        end

        // Reset during MEASURE, then restart from channel 0.
        wait_rise(cyc, ch);
        goto_off(5); echo_in[ch] = 1'b1;
        goto_off(30);
        n_rst = 1'b0;
        echo_in = '0;
        #1;
        chk("rst_trigger", 64'(trigger_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(dist_valid), 64'(0));
        chk("rst_data", 64'(dist_data), 64'(0));
        chk("rst_all", 64'(dist_all), 64'(0));
        repeat (3) tick();
        n_rst = 1'b1;
        wait_rise(cyc, ch);
        chk("restart_ch", 64'(ch), 64'(0));
        chk("restart_trigger", 64'(trigger_out), 64'(1));
        goto_off(5); echo_in[0] = 1'b1;
        goto_off(15); echo_in[0] = 1'b0;
        wait_valid(vc);
        chk("restart_data", 64'(dist_data), 64'(34));
        chk("restart_dist_ch", 64'(dist_ch), 64'(0));

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcsr04_multi_ranger.md
# hcsr04_multi_ranger

Parametrised multi-channel controller for HC-SR04-class ultrasonic sensors. It fires N_CH sensors one at a time in round-robin slots so they cannot hear each other's echoes. For each slot it measures the echo pulse width, converts it to a scaled, saturated distance and publishes it with a valid strobe, channel tag and timeout flag. It sits between the sensor pins and the display/processing logic, and keeps a latest-value bank of all channels.

## Interface
- N_CH, 4: number of sensors.
- CH_W, 2: channel index width; must satisfy 2^CH_W >= N_CH.
- TRIG_CYCLES, 500: trigger pulse length in clocks (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: slot length in clocks (60 ms); must exceed TRIG_CYCLES + 2.
- CNT_W, 22: slot/width counter width; 2^CNT_W > PERIOD_CYCLES.
- SCALE, 891: unsigned 10-bit distance multiplier.
- SHIFT, 18: right shift applied to width*SCALE.
- DIST_W, 12: distance output width.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- en  in  1  1 = keep cycling slots; 0 = stop after the current slot.
- echo_in  in  N_CH  raw echo lines, bit i = sensor i; asynchronous to clk.
- trigger_out  out  N_CH  trigger lines, at most one bit high.
- dist_data  out  DIST_W  last result.
- dist_ch  out  CH_W  channel of last result.
- dist_timeout  out  1  last result was a timeout.
- dist_valid  out  1  one-cycle strobe: dist_* updated this cycle.
- dist_all  out  N_CH*DIST_W  latest distance per channel; channel i in bits [i*DIST_W +: DIST_W].
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Each echo_in bit passes through a 2-FF synchronizer (echo_s). Only the active channel's echo_s is used.
- The state machine has five states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLD.
- IDLE: when en=1, clear the slot counter cnt to 0, set ch to the current channel and go to TRIG.
- TRIG: trigger_out[ch]=1 while cnt < TRIG_CYCLES. At cnt == TRIG_CYCLES-1 go to WAIT_RISE. Echo is ignored in this state.
- WAIT_RISE: when echo_s=1, set width w=1 and go to MEASURE.
- MEASURE: while echo_s=1, w increments. When echo_s=0, publish the measurement and go to HOLD.
- HOLD: wait for the end of the slot.
- Slot end is cnt == PERIOD_CYCLES-1, in any state except IDLE:
  - if the state is WAIT_RISE, or MEASURE with echo_s still 1, publish a timeout;
  - then advance ch (N_CH-1 wraps to 0), clear cnt, and go to TRIG if en=1, else IDLE.
- Measurement: product = w*SCALE in CNT_W+10 bits; d = product >> SHIFT. If d >= 2^DIST_W, dist_data saturates to all ones. dist_timeout=0.
- Timeout: dist_data = all ones, dist_timeout=1.
- Publishing always updates dist_data, dist_ch and dist_all slot ch, and pulses dist_valid.
- en is sampled only in IDLE and at slot end. Deasserting en mid-slot never truncates the slot.

## Timing
- All outputs reset to 0: trigger_out, dist_*, dist_all, busy. State resets to IDLE, ch and cnt to 0. Reset mid-slot takes effect immediately and drops trigger_out.
- From en rising while IDLE: trigger_out[ch] rises 1 cycle later and stays high exactly TRIG_CYCLES cycles.
- Consecutive slots start exactly PERIOD_CYCLES cycles apart.
- Latency: echo_in pin edge to echo_s is 2 clocks. dist_valid is asserted the cycle after MEASURE sees echo_s=0, and the registered dist_* are valid on that same cycle.
- w equals the echo high time in clocks, within ±1.
- Simultaneous events: if the fall is seen on the slot-end cycle, the measurement wins (no timeout) and the slot still ends on schedule. At most one dist_valid per slot.
- An echo already high when WAIT_RISE is entered counts as a rise.

## Test plan
Bench parameters: N_CH=2, TRIG_CYCLES=4, PERIOD_CYCLES=128, SCALE=891, SHIFT=8, DIST_W=8.
- **Basic measurement:** en=1; after trigger_out[0] falls, echo_in[0] high for 10 clocks -> trigger_out[0] high exactly 4 cycles; dist_valid once, dist_data=34, dist_ch=0, dist_timeout=0, dist_all[7:0]=34.
- **Round-robin:** with en held high, trigger_out[1] rises exactly 128 cycles after trigger_out[0]. Echo_in[1] of 20 clocks -> dist_data=69, dist_ch=1; dist_all[15:8]=69 and dist_all[7:0]=34 is kept.
- **Timeout:** no echo on channel 0 -> at slot end dist_valid with dist_data=255, dist_timeout=1. Separately, echo stuck high through slot end -> same result.
- **Saturation:** echo width 80 -> 80*891>>8 = 278, so dist_data=255 with dist_timeout=0.
- **en and reset:** en dropped mid-slot -> the slot completes, busy then falls, and there is no further trigger. Reset asserted during MEASURE -> all outputs go to 0 asynchronously, and after release the sequence restarts at channel 0.
